// File: rtl/alu_ctrl_pkg.sv
// Shared constants, decode payload and FSM state type for the ALU control pipe.
package alu_ctrl_pkg;

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned OP_W   = 5;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned F7_W   = 7;

  // RV32 major opcodes
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

  // funct7 classes
  localparam logic [F7_W-1:0] F7_BASE   = 7'b0000000;
  localparam logic [F7_W-1:0] F7_ALT    = 7'b0100000;
  localparam logic [F7_W-1:0] F7_MULDIV = 7'b0000001;

  // ALU operation codes
  localparam logic [OP_W-1:0] ALU_ADD    = 5'b00000;
  localparam logic [OP_W-1:0] ALU_SUB    = 5'b00001;
  localparam logic [OP_W-1:0] ALU_AND    = 5'b00010;
  localparam logic [OP_W-1:0] ALU_OR     = 5'b00011;
  localparam logic [OP_W-1:0] ALU_XOR    = 5'b00110;
  localparam logic [OP_W-1:0] ALU_LUI    = 5'b01000;
  localparam logic [OP_W-1:0] ALU_SRL    = 5'b01010;
  localparam logic [OP_W-1:0] ALU_SRA    = 5'b01011;
  localparam logic [OP_W-1:0] ALU_SLL    = 5'b01101;
  localparam logic [OP_W-1:0] ALU_BEQ    = 5'b10000;
  localparam logic [OP_W-1:0] ALU_BNE    = 5'b10001;
  localparam logic [OP_W-1:0] ALU_BLT    = 5'b10010;
  localparam logic [OP_W-1:0] ALU_BGE    = 5'b10011;
  localparam logic [OP_W-1:0] ALU_BLTU   = 5'b10100;
  localparam logic [OP_W-1:0] ALU_BGEU   = 5'b10101;
  localparam logic [OP_W-1:0] ALU_SLT    = 5'b10110;
  localparam logic [OP_W-1:0] ALU_SLTU   = 5'b10111;
  localparam logic [OP_W-1:0] ALU_MUL    = 5'b11000;
  localparam logic [OP_W-1:0] ALU_MULH   = 5'b11001;
  localparam logic [OP_W-1:0] ALU_MULHSU = 5'b11010;
  localparam logic [OP_W-1:0] ALU_MULHU  = 5'b11011;
  localparam logic [OP_W-1:0] ALU_DIV    = 5'b11100;
  localparam logic [OP_W-1:0] ALU_DIVU   = 5'b11101;
  localparam logic [OP_W-1:0] ALU_REM    = 5'b11110;
  localparam logic [OP_W-1:0] ALU_REMU   = 5'b11111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic            illegal;
    logic            multicycle;
    logic            is_div;
  } dec_t;

  // Register/immediate arithmetic selected by funct3 with the base funct7
  function automatic logic [OP_W-1:0] base_op(input logic [F3_W-1:0] f3);
    logic [OP_W-1:0] r;
    r = ALU_ADD;
    case (f3)
      3'b000: r = ALU_ADD;
      3'b001: r = ALU_SLL;
      3'b010: r = ALU_SLT;
      3'b011: r = ALU_SLTU;
      3'b100: r = ALU_XOR;
      3'b101: r = ALU_SRL;
      3'b110: r = ALU_OR;
      3'b111: r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_ctrl_pipe_if.sv
// ID-side issue handshake and EX-side decoded-op handshake.
interface alu_ctrl_pipe_if;
  import alu_ctrl_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OPC_W-1:0]  ALUOp;
  logic [F3_W-1:0]   funct3;
  logic [F7_W-1:0]   funct7;
  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   ALU_operation;
  logic              illegal;
  logic              multicycle;
  logic              busy;

  modport slave (
    input  in_valid, ALUOp, funct3, funct7, out_ready,
    output in_ready, out_valid, ALU_operation, illegal, multicycle, busy
  );

  modport master (
    output in_valid, ALUOp, funct3, funct7, out_ready,
    input  in_ready, out_valid, ALU_operation, illegal, multicycle, busy
  );
endinterface

// File: rtl/alu_op_decode.sv
// Pure combinational RV32I(+M) opcode/funct decode into the ALU operation code.
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [F3_W-1:0]  funct3,
  input  logic [F7_W-1:0]  funct7,
  output dec_t             dec
);

  // Illegal paths leave op at ADD (00000) and only raise illegal
  always_comb begin
    dec = '0;
    case (opcode)
      OPC_LUI: dec.op = ALU_LUI;
      OPC_AUIPC, OPC_JAL, OPC_JALR: dec.op = ALU_ADD;
      OPC_LOAD: begin
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: dec.op = ALU_ADD;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        case (funct3)
          3'b000, 3'b001, 3'b010: dec.op = ALU_ADD;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_BRANCH: begin
        case (funct3)
          3'b000: dec.op = ALU_BEQ;
          3'b001: dec.op = ALU_BNE;
          3'b100: dec.op = ALU_BLT;
          3'b101: dec.op = ALU_BGE;
          3'b110: dec.op = ALU_BLTU;
          3'b111: dec.op = ALU_BGEU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_OP: begin
        case (funct7)
          F7_BASE: dec.op = base_op(funct3);
          F7_ALT: begin
            case (funct3)
              3'b000: dec.op = ALU_SUB;
              3'b101: dec.op = ALU_SRA;
              default: dec.illegal = 1'b1;
            endcase
          end
          F7_MULDIV: begin
            if (ENABLE_M) begin
              dec.op         = {2'b11, funct3};
              dec.multicycle = 1'b1;
              dec.is_div     = funct3[2];
            end else begin
              dec.illegal = 1'b1;
            end
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        case (funct3)
          3'b001: begin
            if (funct7 == F7_BASE) dec.op = ALU_SLL;
            else                   dec.illegal = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     dec.op = ALU_SRL;
            else if (funct7 == F7_ALT) dec.op = ALU_SRA;
            else                       dec.illegal = 1'b1;
          end
          default: dec.op = base_op(funct3);
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control stage between ID and EX; holds off issue while an M op occupies EX.
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter bit          ENABLE_M   = 1'b1,
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned DIV_CYCLES = 33
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  alu_ctrl_pipe_if.slave  bus
);

  localparam logic [CNT_W-1:0] MUL_LAT_M1 = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAT_M1 = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             ill_q, ill_d;
  logic             mc_q, mc_d;
  logic             out_valid_q;
  logic             busy_q;
  logic             in_ready_c;
  logic             accept_c;
  logic             load_c;
  logic [CNT_W-1:0] lat_m1_c;
  dec_t             dec_c;

  alu_op_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_dec (
    .opcode (bus.ALUOp),
    .funct3 (bus.funct3),
    .funct7 (bus.funct7),
    .dec    (dec_c)
  );

  // Accept when empty, or when the held op retires this cycle; never during flush
  assign in_ready_c = !flush &&
                      ((state_q == ST_EMPTY) || ((state_q == ST_FULL) && bus.out_ready));
  assign accept_c   = bus.in_valid && in_ready_c;
  assign lat_m1_c   = dec_c.is_div ? DIV_LAT_M1 : MUL_LAT_M1;

  // Next-state, countdown and entry capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ill_d   = ill_q;
    mc_d    = mc_q;
    load_c  = 1'b0;

    unique case (state_q)
      ST_EMPTY: load_c = accept_c;
      ST_BUSY: begin
        // The edge that takes the count to zero also presents the op
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_FULL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FULL: begin
        if (bus.out_ready) begin
          load_c = accept_c;
          if (!accept_c) state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (load_c) begin
      op_d  = dec_c.op;
      ill_d = dec_c.illegal;
      mc_d  = dec_c.multicycle;
      if (dec_c.multicycle && (lat_m1_c != '0)) begin
        state_d = ST_BUSY;
        cnt_d   = lat_m1_c;
      end else begin
        state_d = ST_FULL;
        cnt_d   = '0;
      end
    end

    if (flush) begin
      state_d = ST_EMPTY;
      cnt_d   = '0;
      op_d    = '0;
      ill_d   = 1'b0;
      mc_d    = 1'b0;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_EMPTY;
      cnt_q       <= '0;
      op_q        <= '0;
      ill_q       <= 1'b0;
      mc_q        <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      ill_q       <= ill_d;
      mc_q        <= mc_d;
      out_valid_q <= (state_d == ST_FULL);
      busy_q      <= (state_d == ST_BUSY);
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.out_valid     = out_valid_q;
  assign bus.ALU_operation = op_q;
  assign bus.illegal       = ill_q;
  assign bus.multicycle    = mc_q;
  assign bus.busy          = busy_q;

endmodule
